// File: rtl/oam_dma.sv
// oam_dma: GameBoy OAM DMA engine; copies LENGTH bytes from page src_hi into OAM, one byte every STRIDE clocks.
module oam_dma #(
    parameter int LENGTH = 160,
    parameter int STRIDE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_wr,
    input  logic [7:0]  dma_data,
    output logic [7:0]  dma_reg,
    output logic        dma_active,
    output logic        dma_re,
    output logic [15:0] dma_addr,
    input  logic [7:0]  dma_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        dma_done
);
    localparam int WW = (STRIDE > 4) ? $clog2(STRIDE) : 1;
    localparam logic [WW-1:0] WAIT_INIT = WW'((STRIDE > 3) ? STRIDE - 4 : 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_READ, S_LATCH, S_WRITE, S_WAIT} state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_src, r_idx, r_reg, r_wdata;
    logic [WW-1:0]   r_wait;
    logic            r_done;
    logic [7:0]      w_src;
    logic            w_last, w_byte_done;

    // Echo RAM (E000-FDFF) mirrors C000-DDFF
    assign w_src       = (dma_data >= 8'hE0) ? dma_data - 8'h20 : dma_data;
    assign w_last      = r_idx == 8'(LENGTH - 1);
    assign w_byte_done = (r_state == S_WRITE && STRIDE == 3) || (r_state == S_WAIT && r_wait == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_idx   <= '0;
            r_reg   <= '0;
            r_wdata <= '0;
            r_wait  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_byte_done && w_last && !dma_wr;
            if (dma_wr) begin
                r_reg <= dma_data;
                r_src <= w_src;
            end
            if (dma_wr)
                r_idx <= '0;
            else if (w_byte_done && !w_last)
                r_idx <= r_idx + 8'd1;
            if (r_state == S_LATCH)
                r_wdata <= dma_rdata;
            if (r_state == S_WRITE)
                r_wait <= WAIT_INIT;
            else if (r_state == S_WAIT)
                r_wait <= r_wait - WW'(1);
        end
    end

    // A CPU write restarts the engine from any state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_IDLE;
            S_START: w_next = S_READ;
            S_READ:  w_next = S_LATCH;
            S_LATCH: w_next = S_WRITE;
            S_WRITE: w_next = !w_byte_done ? S_WAIT : (w_last ? S_IDLE : S_READ);
            S_WAIT:  w_next = !w_byte_done ? S_WAIT : (w_last ? S_IDLE : S_READ);
            default: w_next = S_IDLE;
        endcase
        if (dma_wr)
            w_next = S_START;
    end

    always_comb begin
        dma_active = r_state != S_IDLE;
        dma_re     = r_state == S_READ;
        dma_addr   = (r_state == S_READ) ? {r_src, r_idx} : 16'h0000;
        oam_we     = r_state == S_WRITE;
        oam_addr   = (r_state == S_WRITE) ? r_idx : 8'h00;
    end

    assign dma_reg   = r_reg;
    assign oam_wdata = r_wdata;
    assign dma_done  = r_done;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: vector-table and randomized checks of oam_dma (STRIDE 4 and 3) against a cycle-level reference model.
module tb_oam_dma;
    localparam int LEN  = 160;
    localparam int BIG  = 1 << 30;
    localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_RISE = 3, K_FALL = 4;

    typedef struct {
        int d;
        int cls;
        int c;
        int k;
        int a;
        int v;
    } ev_t;

    typedef struct {
        logic [7:0] d0;
        int         rs_at;
        logic [7:0] d1;
        int         rst_at;
        int         done_a;
        int         done_b;
        int         ndone_a;
        int         ndone_b;
        logic [7:0] reg_exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             dma_wr = 1'b0;
    logic [7:0]       dma_data = 8'h00;
    logic [1:0][7:0]  reg_o, oaddr_o, wdata_o, rdata_i;
    logic [1:0][15:0] addr_o;
    logic [1:0]       act_o, re_o, we_o, done_o;

    oam_dma #(.LENGTH(LEN), .STRIDE(4)) dut_a (
        .clk(clk), .rst(rst), .dma_wr(dma_wr), .dma_data(dma_data),
        .dma_reg(reg_o[0]), .dma_active(act_o[0]), .dma_re(re_o[0]), .dma_addr(addr_o[0]),
        .dma_rdata(rdata_i[0]), .oam_we(we_o[0]), .oam_addr(oaddr_o[0]),
        .oam_wdata(wdata_o[0]), .dma_done(done_o[0])
    );

    oam_dma #(.LENGTH(LEN), .STRIDE(3)) dut_b (
        .clk(clk), .rst(rst), .dma_wr(dma_wr), .dma_data(dma_data),
        .dma_reg(reg_o[1]), .dma_active(act_o[1]), .dma_re(re_o[1]), .dma_addr(addr_o[1]),
        .dma_rdata(rdata_i[1]), .oam_we(we_o[1]), .oam_addr(oaddr_o[1]),
        .oam_wdata(wdata_o[1]), .dma_done(done_o[1])
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         t0 = 0;
    int         qbase = 0;
    bit         log_en = 1'b0;
    logic [1:0] prev_act = 2'b00;
    logic [7:0] mem [65536];
    logic [7:0] oam [2][256];
    logic [7:0] oam_exp [2][256];
    ev_t        act_q[$];
    ev_t        exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         nw, rc;
    int         wc [2];
    logic [7:0] wd [2];
    vec_t       tbl [8];

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency memory per engine
    always @(posedge clk)
        for (int d = 0; d < 2; d++)
            if (re_o[d]) rdata_i[d] <= mem[addr_o[d]];

    always @(negedge clk)
        if (log_en)
            for (int d = 0; d < 2; d++) begin
                if (re_o[d]) act_q.push_back('{d, 0, cyc - t0, K_RD, int'(addr_o[d]), 0});
                if (we_o[d]) begin
                    act_q.push_back('{d, 0, cyc - t0, K_WR, int'(oaddr_o[d]), int'(wdata_o[d])});
                    oam[d][oaddr_o[d]] = wdata_o[d];
                end
                if (done_o[d]) act_q.push_back('{d, 0, cyc - t0, K_DONE, 0, 0});
                if (act_o[d] != prev_act[d]) act_q.push_back('{d, 1, cyc - t0, act_o[d] ? K_RISE : K_FALL, 0, 0});
                prev_act[d] = act_o[d];
            end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic longint outs(input int d);
        return longint'({reg_o[d], act_o[d], re_o[d], addr_o[d], we_o[d], oaddr_o[d], wdata_o[d], done_o[d]});
    endfunction

    function automatic int find_ev(input int d, input int k, input int c);
        for (int i = qbase; i < act_q.size(); i++)
            if (act_q[i].d == d && act_q[i].k == k && act_q[i].c == c) return i;
        return -1;
    endfunction

    function automatic int ev_a(input int d, input int k, input int c);
        int i;
        i = find_ev(d, k, c);
        return (i < 0) ? -1 : act_q[i].a;
    endfunction

    function automatic int count_k(input int d, input int k);
        int n;
        n = 0;
        for (int i = qbase; i < act_q.size(); i++)
            if (act_q[i].d == d && act_q[i].k == k) n++;
        return n;
    endfunction

    // Reference: byte i of a transfer started at w reads at w+2+i*S and writes at w+4+i*S;
    // done at w+2+LEN*S; anything after the next write (restart) or a reset is dropped.
    task automatic build_exp(input int d, input int s);
        int lim, src, st, en, pe, c;
        pe = -100;
        for (int k = 0; k < nw; k++) begin
            lim = (k + 1 < nw) ? wc[k+1] : BIG;
            if (rc >= wc[k] && rc < lim) lim = rc;
            src = (wd[k] >= 8'hE0) ? int'(wd[k]) - 32 : int'(wd[k]);
            for (int i = 0; i < LEN; i++) begin
                c = wc[k] + 2 + i * s;
                if (c <= lim) exp_q.push_back('{d, 0, c, K_RD, src * 256 + i, 0});
                if (c + 2 <= lim) begin
                    exp_q.push_back('{d, 0, c + 2, K_WR, i, int'(mem[src * 256 + i])});
                    oam_exp[d][i] = mem[src * 256 + i];
                end
            end
            c = wc[k] + 2 + LEN * s;
            if (c <= lim) exp_q.push_back('{d, 0, c, K_DONE, 0, 0});
            st = wc[k] + 1;
            en = (c - 1 < lim) ? c - 1 : lim;
            if (st != pe + 1) begin
                if (pe >= 0) exp_q.push_back('{d, 1, pe + 1, K_FALL, 0, 0});
                exp_q.push_back('{d, 1, st, K_RISE, 0, 0});
            end
            pe = en;
        end
        exp_q.push_back('{d, 1, pe + 1, K_FALL, 0, 0});
    endtask

    task automatic cmp_stream(input int d, input int cls, input string nm);
        int na, ne, ia, ie;
        na = 0;
        ne = 0;
        for (int i = qbase; i < act_q.size(); i++) if (act_q[i].d == d && act_q[i].cls == cls) na++;
        for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].d == d && exp_q[i].cls == cls) ne++;
        chk({nm, "_count"}, na, ne);
        ia = qbase;
        ie = 0;
        for (int n = 0; n < ne && n < na; n++) begin
            while (!(act_q[ia].d == d && act_q[ia].cls == cls)) ia++;
            while (!(exp_q[ie].d == d && exp_q[ie].cls == cls)) ie++;
            n_chk++;
            if (act_q[ia].c != exp_q[ie].c || act_q[ia].k != exp_q[ie].k ||
                act_q[ia].a != exp_q[ie].a || act_q[ia].v != exp_q[ie].v) begin
                n_fail++;
                $display("FAIL %s[%0d]: got cyc=%0d kind=%0d addr=%0h data=%0h, expected cyc=%0d kind=%0d addr=%0h data=%0h",
                         nm, n, act_q[ia].c, act_q[ia].k, act_q[ia].a, act_q[ia].v,
                         exp_q[ie].c, exp_q[ie].k, exp_q[ie].a, exp_q[ie].v);
                break;
            end
            ia++;
            ie++;
        end
    endtask

    task automatic run_scen(input int sid);
        int endrel, lastw, nbad;
        dma_wr = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        lastw = wc[nw-1];
        endrel = ((rc > lastw) ? rc : lastw) + 8 + LEN * 4;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) oam_exp[d][i] = oam[d][i];
        exp_q.delete();
        build_exp(0, 4);
        build_exp(1, 3);
        qbase = act_q.size();
        t0 = cyc + 1;
        log_en = 1'b1;
        for (int r = 0; r <= endrel; r++) begin
            step();
            dma_wr = 1'b0;
            rst = 1'b0;
            for (int k = 0; k < nw; k++)
                if (r == wc[k]) begin
                    dma_wr = 1'b1;
                    dma_data = wd[k];
                end
            if (r == rc) rst = 1'b1;
            if (rc >= 0 && r == rc + 1)
                for (int d = 0; d < 2; d++) chk($sformatf("s%0d_d%0d_outs_after_rst", sid, d), outs(d), 0);
        end
        step();
        log_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cmp_stream(d, 0, $sformatf("s%0d_d%0d_strobes", sid, d));
            cmp_stream(d, 1, $sformatf("s%0d_d%0d_active", sid, d));
            nbad = 0;
            for (int i = 0; i < 256; i++) if (oam[d][i] !== oam_exp[d][i]) nbad++;
            chk($sformatf("s%0d_d%0d_oam_bad_bytes", sid, d), nbad, 0);
            chk($sformatf("s%0d_d%0d_dma_reg", sid, d), reg_o[d], (rc > lastw) ? 0 : int'(wd[nw-1]));
        end
    endtask

    initial begin
        int nd, ld;
        tbl[0] = '{8'hC0,  -1, 8'h00,  -1,  642,  482, 1, 1, 8'hC0};
        tbl[1] = '{8'hE1,  -1, 8'h00,  -1,  642,  482, 1, 1, 8'hE1};
        tbl[2] = '{8'hC0, 100, 8'hD0,  -1,  742,  582, 1, 1, 8'hD0};
        tbl[3] = '{8'hC0,  -1, 8'h00, 300,   -1,   -1, 0, 0, 8'h00};
        tbl[4] = '{8'h80,  -1, 8'h00,  -1,  642,  482, 1, 1, 8'h80};
        tbl[5] = '{8'hC0, 641, 8'h33,  -1, 1283, 1123, 1, 2, 8'h33};
        tbl[6] = '{8'hC0, 642, 8'hF5,  -1, 1284, 1124, 2, 2, 8'hF5};
        tbl[7] = '{8'hDF,  -1, 8'h00,  -1,  642,  482, 1, 1, 8'hDF};
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < LEN; i++) mem[16'hC000 + i] = 8'(i) ^ 8'h5A;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) chk($sformatf("reset_outs_d%0d", d), outs(d), 0);

        for (int v = 0; v < 8; v++) begin
            wc[0] = 0;
            wd[0] = tbl[v].d0;
            wc[1] = tbl[v].rs_at;
            wd[1] = tbl[v].d1;
            nw = (tbl[v].rs_at >= 0) ? 2 : 1;
            rc = tbl[v].rst_at;
            run_scen(v);
            for (int d = 0; d < 2; d++) begin
                nd = 0;
                ld = -1;
                for (int i = qbase; i < act_q.size(); i++)
                    if (act_q[i].d == d && act_q[i].k == K_DONE) begin
                        nd++;
                        ld = act_q[i].c;
                    end
                chk($sformatf("v%0d_d%0d_ndone", v, d), nd, d ? tbl[v].ndone_b : tbl[v].ndone_a);
                chk($sformatf("v%0d_d%0d_last_done", v, d), ld, d ? tbl[v].done_b : tbl[v].done_a);
                chk($sformatf("v%0d_d%0d_reg", v, d), reg_o[d], tbl[v].reg_exp);
            end
            case (v)
                0: begin
                    chk("b0_read_addr", ev_a(0, K_RD, 2), 'hC000);
                    chk("b0_write_addr", ev_a(0, K_WR, 4), 0);
                    chk("b159_read_addr", ev_a(0, K_RD, 638), 'hC09F);
                    chk("b159_write_addr", ev_a(0, K_WR, 640), 'h9F);
                    chk("active_fall_642", find_ev(0, K_FALL, 642) >= 0, 1);
                    chk("we_pulses", count_k(0, K_WR), 160);
                    chk("we_pulses_s3", count_k(1, K_WR), 160);
                    chk("oam_byte0", oam[0][0], 8'h5A);
                    chk("oam_byte159", oam[0][159], 8'h9F ^ 8'h5A);
                end
                1: begin
                    chk("echo_first_read", ev_a(0, K_RD, 2), 'hC100);
                    chk("echo_last_read", ev_a(0, K_RD, 638), 'hC19F);
                end
                2: begin
                    chk("restart_read_addr", ev_a(0, K_RD, 102), 'hD000);
                    chk("restart_old_write", ev_a(0, K_WR, 100), 24);
                end
                3: chk("reset_write_count", count_k(0, K_WR), 75);
                4: chk("s3_last_read", ev_a(1, K_RD, 479), 'h809F);
                default: ;
            endcase
        end

        for (int s = 0; s < 6; s++) begin
            nw = int'($urandom_range(1, 2));
            wc[0] = 0;
            wd[0] = 8'($urandom);
            wc[1] = int'($urandom_range(1, 700));
            wd[1] = 8'($urandom);
            rc = ($urandom_range(0, 1) == 1) ? wc[nw-1] + int'($urandom_range(1, 700)) : -1;
            run_scen(100 + s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
